// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers and the memory request payload.
package mem_arb_pkg;

    localparam int unsigned MEM_DW = 32;

    typedef logic port_id_t;

    localparam port_id_t PORT_CORE   = 1'b0;
    localparam port_id_t PORT_LOADER = 1'b1;

    typedef struct packed {
        logic              we;
        logic              byte_op;
        logic [MEM_DW-1:0] addr;
        logic [MEM_DW-1:0] wd;
    } mem_req_t;

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way grant: round-robin on ties, port-1 lock bounded by the fairness hit.
module rr_grant2
    import mem_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  port_id_t   last,
    input  logic       lock,
    input  logic       fair_hit,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = 2'b00;
        if (valid0 && valid1) begin
            if (lock) begin
                grant_c = fair_hit ? 2'b01 : 2'b10;
            end else begin
                grant_c = (last == PORT_LOADER) ? 2'b01 : 2'b10;
            end
        end else if (valid0) begin
            grant_c = 2'b01;
        end else if (valid1) begin
            grant_c = 2'b10;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and the loader (port 1).
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOCK_MAX   = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  p0_valid_i,
    input  logic                  p0_we_i,
    input  logic                  p0_byte_op_i,
    input  logic [DATA_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_wd_i,
    output logic                  p0_ready_o,
    output logic                  p0_rvalid_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    input  logic                  p1_valid_i,
    input  logic                  p1_we_i,
    input  logic                  p1_byte_op_i,
    input  logic [DATA_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_wd_i,
    input  logic                  p1_lock_i,
    output logic                  p1_ready_o,
    output logic                  p1_rvalid_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,
    output logic                  mem_we_o,
    output logic                  mem_byte_op_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i
);

    port_id_t              last_q;
    logic                  lock_q, lock_d;
    logic [CNT_WIDTH-1:0]  fair_cnt_q, fair_cnt_d;
    logic                  rvalid_q;
    port_id_t              rsp_port_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  fair_hit;
    logic [1:0]            grant_raw;
    logic [1:0]            grant;
    logic                  accept_rd;
    mem_req_t              req0, req1, req_sel;

    assign fair_hit = (fair_cnt_q == CNT_WIDTH'(LOCK_MAX));

    rr_grant2 u_grant (
        .valid0   (p0_valid_i),
        .valid1   (p1_valid_i),
        .last     (last_q),
        .lock     (lock_q),
        .fair_hit (fair_hit),
        .grant_c  (grant_raw)
    );

    // No request may be accepted while reset is held.
    assign grant      = rst_ni ? grant_raw : 2'b00;
    assign p0_ready_o = grant[0];
    assign p1_ready_o = grant[1];

    always_comb begin
        req0 = '{we: p0_we_i, byte_op: p0_byte_op_i,
                 addr: MEM_DW'(p0_addr_i), wd: MEM_DW'(p0_wd_i)};
        req1 = '{we: p1_we_i, byte_op: p1_byte_op_i,
                 addr: MEM_DW'(p1_addr_i), wd: MEM_DW'(p1_wd_i)};
        req_sel = '0;
        if (grant[0]) begin
            req_sel = req0;
        end else if (grant[1]) begin
            req_sel = req1;
        end
    end

    assign mem_we_o      = req_sel.we;
    assign mem_byte_op_o = req_sel.byte_op;
    assign mem_addr_o    = DATA_WIDTH'(req_sel.addr);
    assign mem_wd_o      = DATA_WIDTH'(req_sel.wd);

    assign accept_rd = (grant[0] && !p0_we_i) || (grant[1] && !p1_we_i);

    // Lock and fairness next-state.
    always_comb begin
        lock_d     = lock_q;
        fair_cnt_d = fair_cnt_q;
        if (!p1_valid_i) begin
            lock_d = 1'b0;
        end else if (grant[1]) begin
            lock_d = p1_lock_i;
        end else if (grant[0] && lock_q) begin
            lock_d = 1'b0;
        end
        if (!p0_valid_i || grant[0]) begin
            fair_cnt_d = '0;
        end else if (grant[1] && !fair_hit) begin
            fair_cnt_d = fair_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= PORT_LOADER;
            lock_q     <= 1'b0;
            fair_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            rsp_port_q <= PORT_CORE;
            rdata_q    <= '0;
        end else begin
            lock_q     <= lock_d;
            fair_cnt_q <= fair_cnt_d;
            rvalid_q   <= accept_rd;
            if (grant[0]) begin
                last_q <= PORT_CORE;
            end else if (grant[1]) begin
                last_q <= PORT_LOADER;
            end
            if (accept_rd) begin
                rdata_q    <= mem_rd_i;
                rsp_port_q <= grant[1] ? PORT_LOADER : PORT_CORE;
            end
        end
    end

    assign p0_rvalid_o = rvalid_q && (rsp_port_q == PORT_CORE);
    assign p1_rvalid_o = rvalid_q && (rsp_port_q == PORT_LOADER);
    assign p0_rdata_o  = rdata_q;
    assign p1_rdata_o  = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table, directed corner sequences, random scoreboard.
module tb_data_mem_arbiter;

    typedef logic [31:0] mem_t [16];

    typedef struct {
        logic        v0;
        logic        v1;
        logic        lk;
        logic        e_r0;
        logic        e_r1;
        logic [31:0] e_addr;
        logic        e_rv0;
        logic        e_rv1;
    } vec_t;

    logic        clk, rst_n;
    logic        p0_valid, p0_we, p0_byte_op, p0_ready, p0_rvalid;
    logic [31:0] p0_addr, p0_wd, p0_rdata;
    logic        p1_valid, p1_we, p1_byte_op, p1_lock, p1_ready, p1_rvalid;
    logic [31:0] p1_addr, p1_wd, p1_rdata;
    logic        mem_we, mem_byte_op;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    mem_t env_mem;
    mem_t shadow;
    int   n_cmp = 0;
    int   n_bad = 0;

    data_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_valid_i(p0_valid), .p0_we_i(p0_we), .p0_byte_op_i(p0_byte_op),
        .p0_addr_i(p0_addr), .p0_wd_i(p0_wd), .p0_ready_o(p0_ready),
        .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_valid_i(p1_valid), .p1_we_i(p1_we), .p1_byte_op_i(p1_byte_op),
        .p1_addr_i(p1_addr), .p1_wd_i(p1_wd), .p1_lock_i(p1_lock),
        .p1_ready_o(p1_ready), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .mem_we_o(mem_we), .mem_byte_op_o(mem_byte_op), .mem_addr_o(mem_addr),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd_fn(mem_t m, logic [5:0] a, logic bop);
        logic [31:0] w;
        w = m[a[5:2]];
        if (bop) return {24'h0, w[8*a[1:0] +: 8]};
        return w;
    endfunction

    function automatic mem_t mem_wr_fn(mem_t m, logic [5:0] a, logic [31:0] wd, logic bop);
        mem_t r;
        r = m;
        if (bop) r[a[5:2]][8*a[1:0] +: 8] = wd[7:0];
        else     r[a[5:2]] = wd;
        return r;
    endfunction

    // Combinational data memory seen by the arbiter.
    always_comb mem_rd = mem_rd_fn(env_mem, mem_addr[5:0], mem_byte_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: environment memory commits the write presented this cycle.
    task automatic tick();
        logic        cw, cb;
        logic [31:0] ca, cd;
        cw = mem_we; cb = mem_byte_op; ca = mem_addr; cd = mem_wd;
        @(posedge clk);
        #1;
        if (cw) env_mem = mem_wr_fn(env_mem, ca[5:0], cd, cb);
        @(negedge clk);
    endtask

    task automatic idle();
        p0_valid = 0; p0_we = 0; p0_byte_op = 0; p0_addr = 0; p0_wd = 0;
        p1_valid = 0; p1_we = 0; p1_byte_op = 0; p1_addr = 0; p1_wd = 0; p1_lock = 0;
    endtask

    function automatic vec_t mkv(logic v0, logic v1, logic lk, logic r0, logic r1,
                                 logic [31:0] a, logic rv0, logic rv1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.lk = lk; v.e_r0 = r0; v.e_r1 = r1;
        v.e_addr = a; v.e_rv0 = rv0; v.e_rv1 = rv1;
        return v;
    endfunction

    vec_t vecs [17];

    // Random-phase reference state.
    logic        m_last, m_lock;
    int          m_cnt;
    logic        m_pend;
    logic        m_pport;
    logic [31:0] m_pdata;

    initial begin
        for (int i = 0; i < 16; i++) env_mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101;

        // Alternating ties, then a locked burst bounded by the fairness counter.
        vecs[0] = mkv(1, 1, 0, 1, 0, 32'h10, 0, 0);
        vecs[1] = mkv(1, 1, 0, 0, 1, 32'h20, 1, 0);
        vecs[2] = mkv(1, 1, 0, 1, 0, 32'h10, 0, 1);
        vecs[3] = mkv(1, 1, 0, 0, 1, 32'h20, 1, 0);
        vecs[4] = mkv(0, 1, 1, 0, 1, 32'h20, 0, 1);
        for (int i = 5; i <= 12; i++) vecs[i] = mkv(1, 1, 1, 0, 1, 32'h20, 0, 1);
        vecs[13] = mkv(1, 1, 1, 1, 0, 32'h10, 0, 1);
        vecs[14] = mkv(1, 1, 1, 0, 1, 32'h20, 1, 0);
        vecs[15] = mkv(0, 0, 0, 0, 0, 32'h0, 0, 1);
        vecs[16] = mkv(0, 0, 0, 0, 0, 32'h0, 0, 0);

        // Reset: requests present but nothing may be granted or written.
        idle();
        rst_n = 0;
        p0_valid = 1; p1_valid = 1; p1_we = 1;
        #1;
        check("rst_ready", 32'({p0_ready, p1_ready}), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        @(negedge clk);
        idle();
        rst_n = 1;
        #1;
        check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h0);
        check("rst_rdata", p0_rdata, 32'h0);
        tick();

        foreach (vecs[i]) begin
            p0_valid = vecs[i].v0; p0_we = 0; p0_addr = 32'h10;
            p1_valid = vecs[i].v1; p1_we = 0; p1_addr = 32'h20; p1_lock = vecs[i].lk;
            #1;
            check($sformatf("vec%0d_ready", i), 32'({p0_ready, p1_ready}),
                  32'({vecs[i].e_r0, vecs[i].e_r1}));
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_rvalid", i), 32'({p0_rvalid, p1_rvalid}),
                  32'({vecs[i].e_rv0, vecs[i].e_rv1}));
            if (vecs[i].e_rv0) check($sformatf("vec%0d_rdata0", i), p0_rdata, 32'hC0DE_0404);
            if (vecs[i].e_rv1) check($sformatf("vec%0d_rdata1", i), p1_rdata, 32'hC0DE_0808);
            tick();
        end
        idle();

        // Port-0 single read with one-cycle latency.
        env_mem[4] = 32'hDEAD_BEEF;
        p0_valid = 1; p0_addr = 32'h10;
        #1;
        check("t1_ready", 32'({p0_ready, p1_ready}), 32'h2);
        tick();
        idle();
        #1;
        check("t1_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h2);
        check("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
        tick();

        // Port-1 byte write then port-0 byte readback.
        p1_valid = 1; p1_we = 1; p1_byte_op = 1; p1_addr = 32'h3; p1_wd = 32'h0000_00A5;
        #1;
        check("t4_ready", 32'({p0_ready, p1_ready}), 32'h1);
        check("t4_we", 32'({mem_we, mem_byte_op}), 32'h3);
        check("t4_addr", mem_addr, 32'h3);
        check("t4_wd", 32'(mem_wd[7:0]), 32'hA5);
        tick();
        idle();
        #1;
        check("t4_we_off", 32'(mem_we), 32'h0);
        check("t4_no_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h0);
        p0_valid = 1; p0_byte_op = 1; p0_addr = 32'h3;
        #1;
        check("t4_rd_ready", 32'(p0_ready), 32'h1);
        tick();
        idle();
        #1;
        check("t4_rd_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h2);
        check("t4_rd_data", p0_rdata, 32'h0000_00A5);
        tick();

        // Reset between acceptance and response drops the response.
        p0_valid = 1; p0_addr = 32'h20;
        #1;
        check("t5_ready", 32'(p0_ready), 32'h1);
        #1;
        rst_n = 0;
        #1;
        check("t5_rst_ready", 32'({p0_ready, p1_ready}), 32'h0);
        check("t5_rst_we", 32'(mem_we), 32'h0);
        tick();
        idle();
        rst_n = 1;
        #1;
        check("t5_no_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'h0);
        tick();
        check("t5_no_rvalid2", 32'({p0_rvalid, p1_rvalid}), 32'h0);
        p0_valid = 1; p1_valid = 1; p0_addr = 32'h4; p1_addr = 32'h8;
        #1;
        check("t5_tie", 32'({p0_ready, p1_ready}), 32'h2);
        tick();
        idle();

        // Clean start for the random scoreboard phase.
        rst_n = 0;
        tick();
        rst_n = 1;
        shadow  = env_mem;
        m_last  = 1; m_lock = 0; m_cnt = 0; m_pend = 0; m_pport = 0; m_pdata = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic g0, g1, fh, both;
            if (!p0_valid || p0_ready) begin
                p0_valid   = ($urandom_range(0, 3) != 0);
                p0_we      = ($urandom_range(0, 2) == 0);
                p0_byte_op = 1'($urandom_range(0, 1));
                p0_addr    = 32'($urandom_range(0, 63));
                p0_wd      = $urandom;
            end
            if (!p1_valid || p1_ready) begin
                p1_valid   = ($urandom_range(0, 3) != 0);
                p1_we      = ($urandom_range(0, 2) == 0);
                p1_byte_op = 1'($urandom_range(0, 1));
                p1_addr    = 32'($urandom_range(0, 63));
                p1_wd      = $urandom;
            end
            p1_lock = ($urandom_range(0, 3) != 0);
            #1;
            both = p0_valid && p1_valid;
            fh   = (m_cnt == 8);
            g0 = 0; g1 = 0;
            if (both) begin
                if (m_lock) begin g0 = fh; g1 = !fh; end
                else        begin g0 = m_last; g1 = !m_last; end
            end else begin
                g0 = p0_valid; g1 = p1_valid;
            end
            check("rnd_grant", 32'({p0_ready, p1_ready}), 32'({g0, g1}));
            check("rnd_rvalid", 32'({p0_rvalid, p1_rvalid}),
                  32'({m_pend && !m_pport, m_pend && m_pport}));
            if (m_pend) check("rnd_rdata", m_pport ? p1_rdata : p0_rdata, m_pdata);
            if (g0)      check("rnd_mem0", {mem_addr[30:0], mem_we}, {p0_addr[30:0], p0_we});
            else if (g1) check("rnd_mem1", {mem_addr[30:0], mem_we}, {p1_addr[30:0], p1_we});
            else         check("rnd_mem_idle", 32'(mem_we), 32'h0);
            m_pend = 0;
            if (g0) begin
                if (p0_we) shadow = mem_wr_fn(shadow, p0_addr[5:0], p0_wd, p0_byte_op);
                else begin
                    m_pend = 1; m_pport = 0;
                    m_pdata = mem_rd_fn(shadow, p0_addr[5:0], p0_byte_op);
                end
            end else if (g1) begin
                if (p1_we) shadow = mem_wr_fn(shadow, p1_addr[5:0], p1_wd, p1_byte_op);
                else begin
                    m_pend = 1; m_pport = 1;
                    m_pdata = mem_rd_fn(shadow, p1_addr[5:0], p1_byte_op);
                end
            end
            if (!p1_valid)           m_lock = 0;
            else if (g1)             m_lock = p1_lock;
            else if (g0 && m_lock)   m_lock = 0;
            if (!p0_valid || g0)     m_cnt = 0;
            else if (g1 && m_cnt < 8) m_cnt++;
            if (g0) m_last = 0;
            else if (g1) m_last = 1;
            tick();
        end
        idle();
        #1;
        check("rnd_last_rvalid", 32'({p0_rvalid, p1_rvalid}),
              32'({m_pend && !m_pport, m_pend && m_pport}));
        for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), env_mem[i], shadow[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
